dbus_master: RTL and testbench

DBUS_MASTER -- requirements
Module: dbus_master

---
 rtl/dbus_master.sv | 216 +++++++++++++++++++++
 tb/tb_dbus_master.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_master.sv
// rtl/dbus_master.sv - single-outstanding load/store data-bus master
//
// Purpose:
//   Accepts one load/store request at a time and turns it into a data-bus
//   cycle (cyc/w_en/sel_byte/addr/w_data). It waits for the peripheral ack
//   and returns a one-cycle response with aligned and extended load data.
//   Misaligned or illegal-size accesses get an error response and never
//   start a bus cycle.
//
// Build option:
//   DBUS_TIMEOUT_EN - when defined, a BUS phase that lasts TIMEOUT_CYCLES
//                     cycles without ack is aborted with an error response.
//
// Ports:
//   clk, rst        - rising-edge clock, asynchronous active-high reset
//   req_*_i         - request valid/we/size/unsigned/addr/wdata
//   req_ready_o     - high while idle (request can be accepted)
//   rsp_valid_o     - one-cycle completion pulse
//   rsp_rdata_o     - extended load data (0 for stores and errors)
//   rsp_err_o       - misaligned/illegal access or timeout
//   dbus2peri_o     - bus request to peripherals/memory
//   peri2dbus_i     - ack and read data from the selected peripheral

package dbus_pkg;
  localparam int XLEN = 32;

  typedef struct packed {
    logic            cyc;
    logic            w_en;
    logic [3:0]      sel_byte;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] w_data;
  } type_dbus2peri_s;

  typedef struct packed {
    logic            ack;
    logic [XLEN-1:0] r_data;
  } type_peri2dbus_s;
endpackage

module dbus_master
  import dbus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_i,
  input  logic            req_we_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_unsigned_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            req_ready_o,
  output logic            rsp_valid_o,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o,
  output type_dbus2peri_s dbus2peri_o,
  input  type_peri2dbus_s peri2dbus_i
);

  if (TIMEOUT_CYCLES < 1) begin : g_tmo_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e          state_q;
  type_dbus2peri_s bus_q;
  logic            we_q;
  logic [1:0]      size_q;
  logic            unsigned_q;
  logic [1:0]      addr_lo_q;
  logic            rsp_valid_q;
  logic            rsp_err_q;
  logic [XLEN-1:0] rsp_rdata_q;

`ifdef DBUS_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_q;
`endif

  // Request decode, evaluated on the incoming request in IDLE
  logic [3:0]      sel_d;
  logic [XLEN-1:0] wdata_d;
  logic            illegal_d;

  always_comb begin
    sel_d   = 4'b1111;
    wdata_d = req_wdata_i;
    unique case (req_size_i)
      2'b00: begin
        sel_d   = 4'b0001 << req_addr_i[1:0];
        wdata_d = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        sel_d   = 4'b0011 << {req_addr_i[1], 1'b0};
        wdata_d = {2{req_wdata_i[15:0]}};
      end
      default: begin
        sel_d   = 4'b1111;
        wdata_d = req_wdata_i;
      end
    endcase
    illegal_d = (req_size_i == 2'b11) ||
                ((req_size_i == 2'b01) && req_addr_i[0]) ||
                ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00));
  end

  // Load data: bring the addressed lane down to bit 0, then extend
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_data_d;

  always_comb begin
    shifted     = peri2dbus_i.r_data >> {addr_lo_q, 3'b000};
    load_data_d = shifted;
    unique case (size_q)
      2'b00: load_data_d = unsigned_q ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                      : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      2'b01: load_data_d = unsigned_q ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                      : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      default: load_data_d = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bus_q       <= '0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      unsigned_q  <= 1'b0;
      addr_lo_q   <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef DBUS_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req_i) begin
            we_q       <= req_we_i;
            size_q     <= req_size_i;
            unsigned_q <= req_unsigned_i;
            addr_lo_q  <= req_addr_i[1:0];
            if (illegal_d) begin
              // Error response straight away; the bus is never touched
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q        <= S_BUS;
              bus_q.cyc      <= 1'b1;
              bus_q.w_en     <= req_we_i;
              bus_q.sel_byte <= sel_d;
              bus_q.addr     <= {req_addr_i[XLEN-1:2], 2'b00};
              bus_q.w_data   <= wdata_d;
`ifdef DBUS_TIMEOUT_EN
              tmo_q          <= '0;
`endif
            end
          end
        end

        S_BUS: begin
          if (peri2dbus_i.ack) begin
            // Bus fields cleared here so cyc drops on the ack edge
            state_q     <= S_RESP;
            bus_q       <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= we_q ? '0 : load_data_d;
          end
`ifdef DBUS_TIMEOUT_EN
          else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            // Last allowed BUS cycle passed without ack
            state_q     <= S_RESP;
            bus_q       <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
`endif
        end

        S_RESP: begin
          state_q     <= S_IDLE;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
        end

        default: begin
          state_q <= S_IDLE;
          bus_q   <= '0;
        end
      endcase
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign dbus2peri_o = bus_q;

endmodule

// File: tb/tb_dbus_master.sv
// tb/tb_dbus_master.sv - directed self-checking bench for dbus_master

module tb_dbus_master;
  import dbus_pkg::*;

  logic            clk;
  logic            rst;
  logic            req_i;
  logic            req_we_i;
  logic [1:0]      req_size_i;
  logic            req_unsigned_i;
  logic [31:0]     req_addr_i;
  logic [31:0]     req_wdata_i;
  logic            req_ready_o;
  logic            rsp_valid_o;
  logic [31:0]     rsp_rdata_o;
  logic            rsp_err_o;
  type_dbus2peri_s dbus2peri_o;
  type_peri2dbus_s peri2dbus_i;

  int n_checks = 0;
  int n_fail   = 0;
  int rsp_cnt  = 0;

  dbus_master #(.TIMEOUT_CYCLES(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req_i),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .req_ready_o    (req_ready_o),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .dbus2peri_o    (dbus2peri_o),
    .peri2dbus_i    (peri2dbus_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Response pulses counted mid-cycle, away from the active edge
  always @(negedge clk) if (rsp_valid_o === 1'b1) rsp_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", req_ready_o); end
    n_checks++; if (dbus2peri_o !== '0) begin n_fail++; $display("FAIL reset_bus: got %h expected 0", dbus2peri_o); end
    n_checks++; if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== 34'h0) begin n_fail++; $display("FAIL reset_rsp: got %b %b %h expected 0 0 0", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
    step(); step();
    rst = 1'b0;
    step();
    n_checks++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b expected 1", req_ready_o); end
  endtask

  task automatic test_store();
    logic [1:0]  sz   [4] = '{2'b00, 2'b01, 2'b10, 2'b00};
    logic [31:0] ad   [4] = '{32'h8000_0003, 32'h8000_0002, 32'h8000_0008, 32'h8000_0001};
    logic [31:0] wd   [4] = '{32'h0000_00AB, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_005A};
    logic [3:0]  esel [4] = '{4'b1000, 4'b1100, 4'b1111, 4'b0010};
    logic [31:0] ewd  [4] = '{32'hABAB_ABAB, 32'hBEEF_BEEF, 32'hCAFE_F00D, 32'h5A5A_5A5A};
    int c0;
    for (int i = 0; i < 4; i++) begin
      c0 = rsp_cnt;
      req_i = 1'b1; req_we_i = 1'b1; req_size_i = sz[i]; req_unsigned_i = 1'b0;
      req_addr_i = ad[i]; req_wdata_i = wd[i];
      step();
      req_i = 1'b0;
      n_checks++; if (dbus2peri_o.cyc !== 1'b1 || dbus2peri_o.w_en !== 1'b1) begin n_fail++; $display("FAIL st%0d_cyc_wen: got %b %b expected 1 1", i, dbus2peri_o.cyc, dbus2peri_o.w_en); end
      n_checks++; if (dbus2peri_o.addr !== (ad[i] & 32'hFFFF_FFFC)) begin n_fail++; $display("FAIL st%0d_addr: got %h expected %h", i, dbus2peri_o.addr, ad[i] & 32'hFFFF_FFFC); end
      n_checks++; if (dbus2peri_o.sel_byte !== esel[i]) begin n_fail++; $display("FAIL st%0d_sel: got %b expected %b", i, dbus2peri_o.sel_byte, esel[i]); end
      n_checks++; if (dbus2peri_o.w_data !== ewd[i]) begin n_fail++; $display("FAIL st%0d_wdata: got %h expected %h", i, dbus2peri_o.w_data, ewd[i]); end
      step();
      n_checks++; if (dbus2peri_o.cyc !== 1'b1 || dbus2peri_o.w_data !== ewd[i] || dbus2peri_o.sel_byte !== esel[i]) begin n_fail++; $display("FAIL st%0d_stable: got cyc %b wdata %h expected 1 %h", i, dbus2peri_o.cyc, dbus2peri_o.w_data, ewd[i]); end
      peri2dbus_i.ack = 1'b1; peri2dbus_i.r_data = 32'hFFFF_FFFF;
      step();
      peri2dbus_i.ack = 1'b0;
      n_checks++; if (dbus2peri_o.cyc !== 1'b0 || dbus2peri_o.w_en !== 1'b0 || dbus2peri_o.sel_byte !== 4'b0) begin n_fail++; $display("FAIL st%0d_drop: got cyc %b wen %b sel %b expected 0 0 0", i, dbus2peri_o.cyc, dbus2peri_o.w_en, dbus2peri_o.sel_byte); end
      n_checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h0) begin n_fail++; $display("FAIL st%0d_rsp: got %b %b %h expected 1 0 0", i, rsp_valid_o, rsp_err_o, rsp_rdata_o); end
      step();
      n_checks++; if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin n_fail++; $display("FAIL st%0d_done: got valid %b ready %b expected 0 1", i, rsp_valid_o, req_ready_o); end
      n_checks++; if (rsp_cnt - c0 !== 1) begin n_fail++; $display("FAIL st%0d_pulses: got %0d expected 1", i, rsp_cnt - c0); end
    end
  endtask

  task automatic test_load();
    logic [1:0]  sz   [6] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b01};
    logic        un   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ad   [6] = '{32'h8000_0002, 32'h8000_0002, 32'h8000_0001, 32'h8000_0003, 32'h8000_0004, 32'h8000_0000};
    logic [31:0] rd   [6] = '{32'h8001_1234, 32'h8001_1234, 32'h0000_F500, 32'h7F00_0000, 32'h1234_5678, 32'h0000_7FFF};
    logic [3:0]  esel [6] = '{4'b1100, 4'b1100, 4'b0010, 4'b1000, 4'b1111, 4'b0011};
    logic [31:0] exp  [6] = '{32'hFFFF_8001, 32'h0000_8001, 32'hFFFF_FFF5, 32'h0000_007F, 32'h1234_5678, 32'h0000_7FFF};
    for (int i = 0; i < 6; i++) begin
      req_i = 1'b1; req_we_i = 1'b0; req_size_i = sz[i]; req_unsigned_i = un[i];
      req_addr_i = ad[i]; req_wdata_i = 32'hFFFF_FFFF;
      step();
      req_i = 1'b0;
      n_checks++; if (dbus2peri_o.cyc !== 1'b1 || dbus2peri_o.w_en !== 1'b0 || dbus2peri_o.sel_byte !== esel[i]) begin n_fail++; $display("FAIL ld%0d_bus: got cyc %b wen %b sel %b expected 1 0 %b", i, dbus2peri_o.cyc, dbus2peri_o.w_en, dbus2peri_o.sel_byte, esel[i]); end
      peri2dbus_i.ack = 1'b1; peri2dbus_i.r_data = rd[i];
      step();
      peri2dbus_i.ack = 1'b0; peri2dbus_i.r_data = 32'h0;
      n_checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_rdata_o !== exp[i]) begin n_fail++; $display("FAIL ld%0d_rdata: got %b %b %h expected 1 0 %h", i, rsp_valid_o, rsp_err_o, rsp_rdata_o, exp[i]); end
      step();
    end
  endtask

  task automatic test_misaligned();
    logic [1:0]  sz [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
    logic        we [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] ad [4] = '{32'h8000_0001, 32'h8000_0003, 32'h8000_0000, 32'h8000_0002};
    for (int i = 0; i < 4; i++) begin
      req_i = 1'b1; req_we_i = we[i]; req_size_i = sz[i]; req_unsigned_i = 1'b0;
      req_addr_i = ad[i]; req_wdata_i = 32'h1111_2222;
      peri2dbus_i.ack = 1'b1; peri2dbus_i.r_data = 32'h5555_5555;
      step();
      req_i = 1'b0;
      n_checks++; if (dbus2peri_o.cyc !== 1'b0 || req_ready_o !== 1'b0) begin n_fail++; $display("FAIL mis%0d_nocyc: got cyc %b ready %b expected 0 0", i, dbus2peri_o.cyc, req_ready_o); end
      n_checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_rdata_o !== 32'h0) begin n_fail++; $display("FAIL mis%0d_rsp: got %b %b %h expected 1 1 0", i, rsp_valid_o, rsp_err_o, rsp_rdata_o); end
      step();
      peri2dbus_i.ack = 1'b0;
      n_checks++; if (dbus2peri_o.cyc !== 1'b0 || rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin n_fail++; $display("FAIL mis%0d_after: got cyc %b valid %b ready %b expected 0 0 1", i, dbus2peri_o.cyc, rsp_valid_o, req_ready_o); end
    end
  endtask

  task automatic test_long_wait();
    int cyc_bad = 0;
    req_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'b10; req_unsigned_i = 1'b0;
    req_addr_i = 32'h8000_0010; req_wdata_i = 32'h0;
    peri2dbus_i.ack = 1'b0;
    step();
    req_i = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (dbus2peri_o.cyc !== 1'b1 || rsp_valid_o !== 1'b0) cyc_bad++;
      step();
    end
    n_checks++; if (cyc_bad !== 0) begin n_fail++; $display("FAIL wait_cyc_held: got %0d cycles without cyc expected 0", cyc_bad); end
`ifdef DBUS_TIMEOUT_EN
    n_checks++; if (dbus2peri_o.cyc !== 1'b0 || rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_rdata_o !== 32'h0) begin n_fail++; $display("FAIL timeout_rsp: got cyc %b %b %b %h expected 0 1 1 0", dbus2peri_o.cyc, rsp_valid_o, rsp_err_o, rsp_rdata_o); end
    step();
`else
    for (int i = 0; i < 36; i++) begin
      if (dbus2peri_o.cyc !== 1'b1 || rsp_valid_o !== 1'b0) cyc_bad++;
      step();
    end
    n_checks++; if (cyc_bad !== 0) begin n_fail++; $display("FAIL nowait_cyc_held: got %0d bad cycles expected 0", cyc_bad); end
    peri2dbus_i.ack = 1'b1; peri2dbus_i.r_data = 32'h0BAD_F00D;
    step();
    peri2dbus_i.ack = 1'b0;
    n_checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL late_ack_rsp: got %b %b %h expected 1 0 0badf00d", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
    step();
`endif
  endtask

  task automatic test_reset_mid_bus();
    int c0;
    c0 = rsp_cnt;
    req_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'b10; req_unsigned_i = 1'b0;
    req_addr_i = 32'h8000_0020; req_wdata_i = 32'h1234_5678;
    step();
    req_i = 1'b0;
    n_checks++; if (dbus2peri_o.cyc !== 1'b1) begin n_fail++; $display("FAIL rstbus_cyc_up: got %b expected 1", dbus2peri_o.cyc); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (dbus2peri_o !== '0 || req_ready_o !== 1'b1) begin n_fail++; $display("FAIL rstbus_async: got bus %h ready %b expected 0 1", dbus2peri_o, req_ready_o); end
    #2 rst = 1'b0;
    peri2dbus_i.ack = 1'b1; peri2dbus_i.r_data = 32'hAAAA_AAAA;
    step(); step(); step();
    peri2dbus_i.ack = 1'b0;
    n_checks++; if (rsp_cnt - c0 !== 0 || dbus2peri_o.cyc !== 1'b0 || req_ready_o !== 1'b1) begin n_fail++; $display("FAIL rstbus_no_rsp: got pulses %0d cyc %b ready %b expected 0 0 1", rsp_cnt - c0, dbus2peri_o.cyc, req_ready_o); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  sz  [4] = '{2'b10, 2'b00, 2'b01, 2'b00};
    logic        un  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ad  [4] = '{32'h8000_0000, 32'h8000_0003, 32'h8000_0002, 32'h8000_0001};
    logic [31:0] exp [4] = '{32'h1122_3344, 32'h0000_0011, 32'h0000_1122, 32'h0000_0033};
    int c0;
    int wait_n;
    c0 = rsp_cnt;
    peri2dbus_i.ack = 1'b1; peri2dbus_i.r_data = 32'h1122_3344;
    for (int i = 0; i < 4; i++) begin
      wait_n = 0;
      while (req_ready_o !== 1'b1 && wait_n < 10) begin step(); wait_n++; end
      n_checks++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_ready_timeout: got %b expected 1", i, req_ready_o); end
      // req_i stays high through BUS and RESP; it must not be re-accepted
      req_i = 1'b1; req_we_i = 1'b0; req_size_i = sz[i]; req_unsigned_i = un[i]; req_addr_i = ad[i];
      step();
      n_checks++; if (dbus2peri_o.cyc !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_cyc: got %b expected 1", i, dbus2peri_o.cyc); end
      step();
      n_checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== exp[i] || dbus2peri_o.cyc !== 1'b0) begin n_fail++; $display("FAIL b2b%0d_rsp: got %b %h cyc %b expected 1 %h 0", i, rsp_valid_o, rsp_rdata_o, dbus2peri_o.cyc, exp[i]); end
      step();
    end
    req_i = 1'b0;
    step(); step(); step();
    peri2dbus_i.ack = 1'b0;
    n_checks++; if (rsp_cnt - c0 !== 4) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 4", rsp_cnt - c0); end
    n_checks++; if (dbus2peri_o.cyc !== 1'b0 || req_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: got cyc %b ready %b expected 0 1", dbus2peri_o.cyc, req_ready_o); end
  endtask

  initial begin
    rst = 1'b1;
    req_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00; req_unsigned_i = 1'b0;
    req_addr_i = 32'h0; req_wdata_i = 32'h0;
    peri2dbus_i = '0;
    test_reset();
    test_store();
    test_load();
    test_misaligned();
    test_long_wait();
    test_reset_mid_bus();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
